// File: rtl/persp_viewport_if.sv
// Bundle of the vertex input stream, the shared-divider port and the
// screen-space output stream of persp_viewport.
// The slave modport is the viewport block's view; the master modport is the
// view of the environment that feeds vertices, runs the divider and takes results.
interface persp_viewport_if #(
    parameter int WIDTH    = 32,
    parameter int VP_SHIFT = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic signed [WIDTH-1:0] in_w;

    logic                    div_start;
    logic signed [WIDTH-1:0] div_a;
    logic signed [WIDTH-1:0] div_b;
    logic                    div_done;
    logic                    div_valid;
    logic                    div_dbz;
    logic                    div_ovf;
    logic signed [WIDTH-1:0] div_val;

    logic                    out_valid;
    logic                    out_ready;
    logic [VP_SHIFT:0]       out_sx;
    logic [VP_SHIFT:0]       out_sy;
    logic                    out_clip;

    modport slave (
        input  in_valid, in_x, in_y, in_w,
        output in_ready,
        output div_start, div_a, div_b,
        input  div_done, div_valid, div_dbz, div_ovf, div_val,
        output out_valid, out_sx, out_sy, out_clip,
        input  out_ready
    );

    modport master (
        output in_valid, in_x, in_y, in_w,
        input  in_ready,
        input  div_start, div_a, div_b,
        output div_done, div_valid, div_dbz, div_ovf, div_val,
        input  out_valid, out_sx, out_sy, out_clip,
        output out_ready
    );
endinterface

// File: rtl/persp_viewport.sv
// Perspective divide and viewport mapping for one vertex at a time.
// x/w and y/w are computed sequentially on a shared external iterative divider;
// each quotient (clip-space, -1.0..+1.0 on screen) is mapped to a pixel index
// in [0, 2^(VP_SHIFT+1)-1]. Divider overflow or divide-by-zero flags the vertex
// as clipped. VP_SHIFT must be smaller than FBITS.
module persp_viewport #(
    parameter int WIDTH    = 32,
    parameter int FBITS    = 16,
    parameter int VP_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    persp_viewport_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_X,
        WAIT_X,
        ISSUE_Y,
        WAIT_Y,
        OUT
    } state_t;

    localparam logic signed [WIDTH-1:0] Q_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] Q_MIN     = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] Q_NEG_ONE = {{(WIDTH-FBITS){1'b1}}, {FBITS{1'b0}}};
    localparam logic signed [WIDTH:0]   ONE_EXT   = (WIDTH+1)'(1) << FBITS;
    localparam logic signed [WIDTH:0]   PIX_MAX   = (WIDTH+1)'((1 << (VP_SHIFT+1)) - 1);

    // Pick the quotient for one axis from the divider status; an overflow
    // saturates towards the sign the true quotient would have had.
    function automatic logic signed [WIDTH-1:0] resolve_q(
        input logic signed [WIDTH-1:0] num,
        input logic signed [WIDTH-1:0] den,
        input logic                    valid,
        input logic                    ovf,
        input logic                    dbz,
        input logic signed [WIDTH-1:0] val
    );
        if (valid) begin
            return val;
        end else if (ovf) begin
            return (num[WIDTH-1] == den[WIDTH-1]) ? Q_MAX : Q_MIN;
        end else if (dbz) begin
            return Q_NEG_ONE;
        end
        return val;
    endfunction

    // Map q in [-1.0, +1.0) to a pixel: bias by +1.0, scale by 2^VP_SHIFT,
    // then clamp. One extra bit keeps the bias from wrapping near +max.
    function automatic logic [VP_SHIFT:0] map_pixel(input logic signed [WIDTH-1:0] q);
        logic signed [WIDTH:0] biased;
        logic signed [WIDTH:0] shifted;
        biased  = $signed({q[WIDTH-1], q}) + ONE_EXT;
        shifted = biased >>> (FBITS - VP_SHIFT);
        if (shifted[WIDTH]) begin
            return '0;
        end else if (shifted > PIX_MAX) begin
            return PIX_MAX[VP_SHIFT:0];
        end
        return shifted[VP_SHIFT:0];
    endfunction

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] w_q, w_d;
    logic signed [WIDTH-1:0] div_a_q, div_a_d;
    logic signed [WIDTH-1:0] div_b_q, div_b_d;
    logic [VP_SHIFT:0]       sx_q, sx_d;
    logic [VP_SHIFT:0]       sy_q, sy_d;
    logic                    clip_q, clip_d;

    logic                    in_ready_c;
    logic                    div_start_c;
    logic signed [WIDTH-1:0] num_c;
    logic signed [WIDTH-1:0] q_c;
    logic                    q_clip_c;
    logic [VP_SHIFT:0]       q_pix_c;

    // Next-state and datapath updates; divider status is only consumed on div_done in WAIT_*.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        clip_d      = clip_q;
        in_ready_c  = 1'b0;
        div_start_c = 1'b0;

        num_c    = (state_q == WAIT_Y) ? y_q : x_q;
        q_c      = resolve_q(num_c, w_q, bus.div_valid, bus.div_ovf, bus.div_dbz, bus.div_val);
        q_clip_c = !bus.div_valid && (bus.div_ovf || bus.div_dbz);
        q_pix_c  = map_pixel(q_c);

        case (state_q)
            IDLE: begin
                in_ready_c = !rst;
                if (bus.in_valid && !rst) begin
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    w_d     = bus.in_w;
                    div_a_d = bus.in_x;
                    div_b_d = bus.in_w;
                    clip_d  = 1'b0;
                    state_d = ISSUE_X;
                end
            end
            ISSUE_X: begin
                div_start_c = 1'b1;
                state_d     = WAIT_X;
            end
            WAIT_X: begin
                if (bus.div_done) begin
                    sx_d    = q_pix_c;
                    clip_d  = clip_q | q_clip_c;
                    div_a_d = y_q;
                    state_d = ISSUE_Y;
                end
            end
            ISSUE_Y: begin
                div_start_c = 1'b1;
                state_d     = WAIT_Y;
            end
            WAIT_Y: begin
                if (bus.div_done) begin
                    sy_d    = q_pix_c;
                    clip_d  = clip_q | q_clip_c;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any vertex in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            clip_q  <= clip_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.div_start = div_start_c;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_sx    = sx_q;
    assign bus.out_sy    = sy_q;
    assign bus.out_clip  = clip_q;

endmodule

// File: tb/tb_persp_viewport.sv
// Bench for persp_viewport: behavioural iterative divider with per-vertex
// latency, directed and random vertices, and a scoreboard of expected pixels.
module tb_persp_viewport;

    localparam int WIDTH    = 32;
    localparam int FBITS    = 16;
    localparam int VP_SHIFT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    persp_viewport_if #(.WIDTH(WIDTH), .VP_SHIFT(VP_SHIFT)) bus ();

    persp_viewport #(.WIDTH(WIDTH), .FBITS(FBITS), .VP_SHIFT(VP_SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0] sx;
        logic [6:0] sy;
        logic       clip;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int                       div_lat   = 3;
    int                       starts    = 0;
    bit                       stray_req = 1'b0;
    bit                       busy      = 1'b0;
    int                       cnt       = 0;
    logic signed [WIDTH-1:0]  lat_a, lat_b;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Q16.16 divide: a / b with the quotient in the same format.
    task automatic div_model(input logic signed [31:0] a, input logic signed [31:0] b,
                             output logic v, output logic d, output logic o,
                             output logic signed [31:0] val);
        longint n, q;
        v = 0; d = 0; o = 0; val = 0;
        if (b == 0) begin
            d = 1;
        end else begin
            n = longint'(a) * 65536;
            q = n / longint'(b);
            if (q > 64'sd2147483647 || q < -64'sd2147483648) o = 1;
            else begin v = 1; val = q[31:0]; end
        end
    endtask

    task automatic axis_exp(input logic signed [31:0] num, input logic signed [31:0] w,
                            output logic [6:0] pix, output logic clip);
        logic v, d, o;
        logic signed [31:0] val;
        longint q, p;
        div_model(num, w, v, d, o, val);
        clip = 0;
        if (v) q = val;
        else if (o) begin q = (num[31] == w[31]) ? 64'sd2147483647 : -64'sd2147483647; clip = 1; end
        else begin q = -65536; clip = 1; end
        p = (q + 65536) >>> 10;
        if (p < 0) p = 0;
        if (p > 127) p = 127;
        pix = p[6:0];
    endtask

    // Behavioural divider: answers div_start after div_lat cycles; status lines carry noise otherwise.
    initial begin
        logic v, d, o;
        logic signed [31:0] val;
        bus.div_done = 0; bus.div_valid = 0; bus.div_dbz = 0; bus.div_ovf = 0; bus.div_val = '0;
        forever begin
            @(posedge clk); #1;
            bus.div_done  = 0;
            bus.div_valid = 1'($urandom);
            bus.div_dbz   = 1'($urandom);
            bus.div_ovf   = 1'($urandom);
            bus.div_val   = $urandom;
            if (rst) begin
                busy = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    check_eq("div_a_hold", 64'(bus.div_a), 64'(lat_a));
                    check_eq("div_b_hold", 64'(bus.div_b), 64'(lat_b));
                    div_model(lat_a, lat_b, v, d, o, val);
                    bus.div_done = 1; bus.div_valid = v; bus.div_dbz = d; bus.div_ovf = o; bus.div_val = val;
                end
            end else if (stray_req) begin
                stray_req     = 0;
                bus.div_done  = 1;
                bus.div_valid = 1;
                bus.div_val   = $urandom;
            end
            if (!rst && bus.div_start) begin
                starts++;
                lat_a = bus.div_a;
                lat_b = bus.div_b;
                busy  = 1;
                cnt   = div_lat;
            end
        end
    end

    task automatic offer(input logic signed [31:0] x, input logic signed [31:0] y,
                         input logic signed [31:0] w, output bit ok);
        ok = 0;
        starts = 0;
        @(posedge clk); #1;
        bus.in_x = x; bus.in_y = y; bus.in_w = w; bus.in_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.in_x = $urandom; bus.in_y = $urandom; bus.in_w = $urandom;
        if (!ok) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic run_vertex(input logic signed [31:0] x, input logic signed [31:0] y,
                              input logic signed [31:0] w, input logic [6:0] esx,
                              input logic [6:0] esy, input logic eclip, input int stall);
        exp_t e, r;
        bit ok, got;
        e.sx = esx; e.sy = esy; e.clip = eclip;
        offer(x, y, w, ok);
        if (!ok) return;
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid) got = 1;
        end
        if (!got) begin
            check_eq("out_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        r = sb.pop_front();
        check_eq("out_sx", 64'(bus.out_sx), 64'(r.sx));
        check_eq("out_sy", 64'(bus.out_sy), 64'(r.sy));
        check_eq("out_clip", 64'(bus.out_clip), 64'(r.clip));
        check_eq("div_starts", 64'(starts), 2);
        check_eq("in_ready_busy", 64'(bus.in_ready), 0);
        for (int i = 0; i < stall; i++) begin
            if (i == 3) stray_req = 1;
            @(negedge clk);
            check_eq("stall_valid", 64'(bus.out_valid), 1);
            check_eq("stall_sx", 64'(bus.out_sx), 64'(r.sx));
            check_eq("stall_sy", 64'(bus.out_sy), 64'(r.sy));
            check_eq("stall_clip", 64'(bus.out_clip), 64'(r.clip));
            check_eq("stall_in_ready", 64'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
        @(negedge clk);
        check_eq("hs_valid", 64'(bus.out_valid), 1);
        @(posedge clk); #1;
        bus.out_ready = 0;
        @(negedge clk);
        check_eq("post_hs_in_ready", 64'(bus.in_ready), 1);
        check_eq("post_hs_valid", 64'(bus.out_valid), 0);
    endtask

    task automatic reset_mid();
        bit ok;
        int ov;
        div_lat = 8;
        offer(32'sh0000_8000, 32'sh0000_8000, 32'sh0001_0000, ok);
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (starts == 2) ok = 1;
        end
        if (!ok) check_eq("wait_y_timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(bus.in_ready), 0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 0);
        check_eq("rst_div_start", 64'(bus.div_start), 0);
        check_eq("rst_div_a", 64'(bus.div_a), 0);
        check_eq("rst_out_sx", 64'(bus.out_sx), 0);
        check_eq("rst_out_clip", 64'(bus.out_clip), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_eq("rst_release_ready", 64'(bus.in_ready), 1);
        ov = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) ov++;
        end
        check_eq("abandoned_no_out", 64'(ov), 0);
        div_lat = 3;
        run_vertex(32'sh0, 32'sh0, 32'sh0001_0000, 7'd64, 7'd64, 1'b0, 0);
    endtask

    initial begin
        logic signed [31:0] rx, ry, rw;
        logic [6:0] esx, esy;
        logic cx, cy;
        bus.in_valid = 0; bus.in_x = '0; bus.in_y = '0; bus.in_w = '0; bus.out_ready = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_in_ready", 64'(bus.in_ready), 0);
        check_eq("reset_out_valid", 64'(bus.out_valid), 0);
        check_eq("reset_div_start", 64'(bus.div_start), 0);
        check_eq("reset_div_b", 64'(bus.div_b), 0);
        check_eq("reset_out_sy", 64'(bus.out_sy), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_eq("first_cycle_ready", 64'(bus.in_ready), 1);
        stray_req = 1;
        repeat (3) @(negedge clk);
        check_eq("idle_stray_valid", 64'(bus.out_valid), 0);
        check_eq("idle_stray_ready", 64'(bus.in_ready), 1);

        div_lat = 3;
        run_vertex(32'sh0000_8000, 32'shFFFF_8000, 32'sh0001_0000, 7'd96, 7'd32, 1'b0, 0);
        div_lat = 5;
        run_vertex(32'sh0001_0000, 32'sh0, 32'sh0002_0000, 7'd96, 7'd64, 1'b0, 10);
        div_lat = 2;
        run_vertex(32'sh0001_2345, -32'sh0000_5000, 32'sh0, 7'd0, 7'd0, 1'b1, 0);
        div_lat = 4;
        run_vertex(32'sh4000_0000, 32'shC000_0000, 32'sh0000_0100, 7'd127, 7'd0, 1'b1, 0);
        div_lat = 1;
        run_vertex(32'sh0002_0000, 32'shFFFE_0000, 32'sh0001_0000, 7'd127, 7'd0, 1'b0, 0);
        reset_mid();

        for (int k = 0; k < 6; k++) begin
            div_lat = int'($urandom_range(1, 6));
            rx = $signed(32'($urandom_range(0, 6 * 65536))) - 32'sd196608;
            ry = $signed(32'($urandom_range(0, 6 * 65536))) - 32'sd196608;
            rw = $signed(32'($urandom_range(0, 8 * 65536))) - 32'sd262144;
            axis_exp(rx, rw, esx, cx);
            axis_exp(ry, rw, esy, cy);
            run_vertex(rx, ry, rw, esx, esy, cx | cy, k % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
